alu_sweep_ctrl: RTL and testbench

ALU_SWEEP_CTRL -- requirements
Module: alu_sweep_ctrl

---
 rtl/alu_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_sweep_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_ctrl.sv
// Accepts an operand pair, sweeps ALU select codes 0..NUM_OPS-1 through an external
// combinational ALU, buffers every result, then streams the results out with valid/ready.
module alu_sweep_ctrl #(
  parameter int unsigned NUM_OPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_res,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_sel,
  output logic [3:0] out_res,
  output logic       out_last,
  output logic       busy
);

  localparam logic [2:0] LastIdx = 3'(NUM_OPS - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDrain} state_e;

  state_e     state_q, state_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] idx_nxt;
  logic [3:0] buf_q [8];
  logic [3:0] buf_d [8];
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_res_q, out_res_d;
  logic       out_last_q, out_last_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    idx_nxt     = idx_q + 3'd1;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          sel_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = StSweep;
        end
      end
      StSweep: begin
        buf_d[sel_q] = alu_res;
        if (sel_q == LastIdx) begin
          sel_d       = 3'd0;
          idx_d       = 3'd0;
          out_valid_d = 1'b1;
          // Read through buf_d so a single-op sweep sees the value written this cycle.
          out_res_d   = buf_d[0];
          out_last_d  = (LastIdx == 3'd0);
          state_d     = StDrain;
        end else begin
          sel_d = sel_q + 3'd1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (out_last_q) begin
            idx_d       = 3'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            state_d     = StIdle;
          end else begin
            idx_d      = idx_nxt;
            out_res_d  = buf_q[idx_nxt];
            out_last_d = (idx_nxt == LastIdx);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_a_q      <= 4'd0;
      op_b_q      <= 4'd0;
      sel_q       <= 3'd0;
      idx_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_res_q   <= 4'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        buf_q[i] <= 4'd0;
      end
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 8; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Gated by rst_n so in_ready reads 0 throughout reset; no path from in_valid.
  assign in_ready  = rst_n && (state_q == StIdle);
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = sel_q;
  assign out_valid = out_valid_q;
  assign out_sel   = idx_q;
  assign out_res   = out_res_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl: two instances (NUM_OPS 8 and 5), each with a modelled ALU,
// checked against expected beat queues computed from the operand arithmetic.
module tb_alu_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready;
  logic [3:0] in_a, in_b;

  logic in_ready8, out_valid8, out_last8, busy8;
  logic [3:0] alu_a8, alu_b8, alu_res8, out_res8;
  logic [2:0] alu_sel8, out_sel8;
  logic in_ready5, out_valid5, out_last5, busy5;
  logic [3:0] alu_a5, alu_b5, alu_res5, out_res5;
  logic [2:0] alu_sel5, out_sel5;

  logic use5 = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_res8 = alu_a8 + alu_b8 + {1'b0, alu_sel8};
  assign alu_res5 = alu_a5 + alu_b5 + {1'b0, alu_sel5};

  alu_sweep_ctrl #(.NUM_OPS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .alu_a(alu_a8), .alu_b(alu_b8), .alu_sel(alu_sel8),
    .alu_res(alu_res8), .out_valid(out_valid8), .out_ready(out_ready),
    .out_sel(out_sel8), .out_res(out_res8), .out_last(out_last8), .busy(busy8)
  );

  alu_sweep_ctrl #(.NUM_OPS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
    .in_a(in_a), .in_b(in_b), .alu_a(alu_a5), .alu_b(alu_b5), .alu_sel(alu_sel5),
    .alu_res(alu_res5), .out_valid(out_valid5), .out_ready(out_ready),
    .out_sel(out_sel5), .out_res(out_res5), .out_last(out_last5), .busy(busy5)
  );

  // Observed view of whichever instance is under test.
  logic o_ready, o_valid, o_last, o_busy;
  logic [3:0] o_a, o_b, o_res;
  logic [2:0] o_sel, o_osel;
  assign o_ready = use5 ? in_ready5  : in_ready8;
  assign o_valid = use5 ? out_valid5 : out_valid8;
  assign o_last  = use5 ? out_last5  : out_last8;
  assign o_busy  = use5 ? busy5      : busy8;
  assign o_a     = use5 ? alu_a5     : alu_a8;
  assign o_b     = use5 ? alu_b5     : alu_b8;
  assign o_res   = use5 ? out_res5   : out_res8;
  assign o_sel   = use5 ? alu_sel5   : alu_sel8;
  assign o_osel  = use5 ? out_sel5   : out_sel8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(o_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_out_valid", 32'(o_valid), 32'd0);
    chk("rst_out_last", 32'(o_last), 32'd0);
    chk("rst_alu_sel", 32'(o_sel), 32'd0);
    chk("rst_alu_a", 32'(o_a), 32'd0);
    chk("rst_alu_b", 32'(o_b), 32'd0);
    chk("rst_out_sel", 32'(o_osel), 32'd0);
    chk("rst_out_res", 32'(o_res), 32'd0);
  endtask

  // One full transaction. Optional stall of stall_len cycles before beat stall_beat.
  // With intrude set, in_valid stays high with a foreign pair after the accept edge.
  task automatic txn(input logic [3:0] a, input logic [3:0] b, input int n,
                     input int stall_beat, input int stall_len, input bit intrude);
    logic [3:0] q[$];
    int cyc;
    int stalls;
    for (int k = 0; k < n; k++) q.push_back(4'(a + b + k));
    stalls = (stall_beat < n) ? stall_len : 0;
    chk("idle_in_ready", 32'(o_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b1;
    tick();
    cyc = 1;
    if (intrude) begin
      in_a = 4'h3;
      in_b = 4'hF;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      chk("sweep_busy", 32'(o_busy), 32'd1);
      chk("sweep_in_ready", 32'(o_ready), 32'd0);
      chk("sweep_alu_sel", 32'(o_sel), 32'(k));
      chk("sweep_alu_a", 32'(o_a), 32'(a));
      chk("sweep_alu_b", 32'(o_b), 32'(b));
      chk("sweep_out_valid", 32'(o_valid), 32'd0);
      tick();
      cyc++;
    end
    for (int j = 0; j < n; j++) begin
      if (j == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          out_ready = 1'b0;
          chk("stall_valid", 32'(o_valid), 32'd1);
          chk("stall_sel", 32'(o_osel), 32'(j));
          chk("stall_res", 32'(o_res), 32'(q[j]));
          chk("stall_last", 32'(o_last), 32'(j == n - 1));
          tick();
          cyc++;
        end
      end
      out_ready = 1'b1;
      chk("beat_valid", 32'(o_valid), 32'd1);
      chk("beat_sel", 32'(o_osel), 32'(j));
      chk("beat_res", 32'(o_res), 32'(q[j]));
      chk("beat_last", 32'(o_last), 32'(j == n - 1));
      chk("drain_in_ready", 32'(o_ready), 32'd0);
      chk("drain_alu_sel", 32'(o_sel), 32'd0);
      chk("drain_alu_a", 32'(o_a), 32'(a));
      chk("drain_busy", 32'(o_busy), 32'd1);
      tick();
      cyc++;
    end
    chk("txn_cycles", 32'(cyc), 32'(1 + 2 * n + stalls));
    chk("post_in_ready", 32'(o_ready), 32'd1);
    chk("post_busy", 32'(o_busy), 32'd0);
    chk("post_out_valid", 32'(o_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 4'h0;
    in_b      = 4'h0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk_reset_vals();
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 32'(o_ready), 32'd1);
    tick();

    // Nominal sweep, then a 3-cycle stall on beat 2.
    txn(4'hA, 4'h2, 8, 99, 0, 1'b0);
    txn(4'hA, 4'h2, 8, 2, 3, 1'b0);
    // Intruding pair held during the transaction; accepted right after it.
    txn(4'hA, 4'h2, 8, 99, 0, 1'b1);
    txn(4'h3, 4'hF, 8, 99, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      txn(4'($urandom), 4'($urandom), 8, int'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset mid-sweep at alu_sel=4.
    in_valid = 1'b1;
    in_a     = 4'hA;
    in_b     = 4'h2;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_reset_sel", 32'(o_sel), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    chk("rerelease_in_ready", 32'(o_ready), 32'd1);
    begin
      int seen_valid;
      seen_valid = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (o_valid !== 1'b0 || o_busy !== 1'b0) seen_valid++;
      end
      chk("no_valid_after_reset", 32'(seen_valid), 32'd0);
    end

    // NUM_OPS=5 instance; both are idle after the reset above.
    use5 = 1'b1;
    #1;
    txn(4'h3, 4'hF, 5, 99, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      txn(4'($urandom), 4'($urandom), 5, int'($urandom_range(0, 4)),
          int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
